// File: rtl/memory_responder.sv
// Single-port load/store responder: a request accepted in IDLE answers after LATENCY edges.
// Stores commit and loads are read on the accepting edge; the formatted response is held until taken.
module memory_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [31:0] mem_q [DEPTH];

   logic          req_err;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   load_val;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;
   logic          wr_en;

   // Request decode: error detection, load formatting, store lane selection.
   always_comb begin
      req_err = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (|req_addr[1:0]))
              | (req_addr[31:2] >= DEPTH_W);
      idx      = req_addr[AW+1:2];
      rd_word  = mem_q[idx];
      rd_shift = rd_word >> {req_addr[1:0], 3'b000};

      load_val = rd_word;
      case (req_size)
         2'b00: load_val = req_unsigned ? {24'd0, rd_shift[7:0]}
                                        : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01: load_val = req_unsigned ? {16'd0, rd_shift[15:0]}
                                        : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: load_val = rd_word;
      endcase

      wr_be   = 4'b0000;
      wr_data = req_wdata;
      case (req_size)
         2'b00: begin
            wr_be   = 4'b0001 << req_addr[1:0];
            wr_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            wr_be   = 4'b1111;
            wr_data = req_wdata;
         end
         default: begin
            wr_be   = 4'b0000;
            wr_data = req_wdata;
         end
      endcase
   end

   // Next-state and response capture; reset overrides everything on its edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      error_d = error_q;
      wr_en   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_en   = req_write & ~req_err;
               rdata_d = (req_write | req_err) ? 32'd0 : load_val;
               error_d = req_err;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         WAIT: begin
            if (cnt_q >= LAT_M1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (reset) begin
         state_d = IDLE;
         cnt_d   = 4'd0;
         rdata_d = 32'd0;
         error_d = 1'b0;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
   end

   // Storage has no reset: contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_error = error_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder (DEPTH=256, LATENCY=2): vector table plus
// hand-written stall and mid-transaction reset sequences.
module tb_memory_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   memory_responder #(.DEPTH(256), .LATENCY(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_error   (resp_error)
   );

   typedef struct {
      string       name;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic u);
      req_write    = w;
      req_addr     = a;
      req_wdata    = d;
      req_size     = s;
      req_unsigned = u;
   endtask

   // Issue one request and check the fixed two-edge response timing and result.
   task automatic run_req(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s, input logic u,
                          input logic [31:0] exp_rdata, input logic exp_err);
      drive(w, a, d, s, u);
      req_valid = 1'b1;
      chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
      step();                                   // accepting edge
      req_valid = 1'b0;
      drive(1'b0, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b0);
      chk({name, ".valid_edge1"}, 32'(resp_valid), 32'd0);
      step();                                   // second edge: response rises
      chk({name, ".valid_edge2"}, 32'(resp_valid), 32'd1);
      chk({name, ".rdata"}, resp_rdata, exp_rdata);
      chk({name, ".error"}, 32'(resp_error), 32'(exp_err));
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      chk({name, ".idle_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      //          name           wr    addr          wdata         sz     uns   rdata         err
      vecs[0]  = '{"st_w_10",    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0};
      vecs[1]  = '{"ld_w_10",    1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{"st_b_13",    1'b1, 32'h0000_0013, 32'h0000_007F, 2'b00, 1'b0, 32'h0,         1'b0};
      vecs[3]  = '{"ld_bs_13",   1'b0, 32'h0000_0013, 32'h0,         2'b00, 1'b0, 32'h0000_007F, 1'b0};
      vecs[4]  = '{"ld_hs_12",   1'b0, 32'h0000_0012, 32'h0,         2'b01, 1'b0, 32'h0000_7FAD, 1'b0};
      vecs[5]  = '{"ld_bu_10",   1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b1, 32'h0000_00EF, 1'b0};
      vecs[6]  = '{"ld_bs_10",   1'b0, 32'h0000_0010, 32'h0,         2'b00, 1'b0, 32'hFFFF_FFEF, 1'b0};
      vecs[7]  = '{"ld_w_11",    1'b0, 32'h0000_0011, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1};
      vecs[8]  = '{"ld_h_13",    1'b0, 32'h0000_0013, 32'h0,         2'b01, 1'b0, 32'h0,         1'b1};
      vecs[9]  = '{"ld_sz3_10",  1'b0, 32'h0000_0010, 32'h0,         2'b11, 1'b0, 32'h0,         1'b1};
      vecs[10] = '{"st_w_11err", 1'b1, 32'h0000_0011, 32'h1111_1111, 2'b10, 1'b0, 32'h0,         1'b1};
      vecs[11] = '{"ld_w_10b",   1'b0, 32'h0000_0010, 32'h0,         2'b10, 1'b0, 32'h7FAD_BEEF, 1'b0};
      vecs[12] = '{"st_w_400",   1'b1, 32'h0000_0400, 32'h5555_5555, 2'b10, 1'b0, 32'h0,         1'b1};
      vecs[13] = '{"st_w_3fc",   1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 2'b10, 1'b0, 32'h0,         1'b0};
      vecs[14] = '{"ld_w_3fc",   1'b0, 32'h0000_03FC, 32'h0,         2'b10, 1'b0, 32'hA5A5_5A5A, 1'b0};
      vecs[15] = '{"ld_hs_3fe",  1'b0, 32'h0000_03FE, 32'h0,         2'b01, 1'b0, 32'hFFFF_A5A5, 1'b0};
      vecs[16] = '{"ld_hu_3fe",  1'b0, 32'h0000_03FE, 32'h0,         2'b01, 1'b1, 32'h0000_A5A5, 1'b0};

      reset      = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
      step();
      step();
      chk("rst.req_ready",  32'(req_ready),  32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.resp_rdata", resp_rdata,      32'd0);
      chk("rst.resp_error", 32'(resp_error), 32'd0);
      reset = 1'b0;
      step();

      foreach (vecs[i])
         run_req(vecs[i].name, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                 vecs[i].size, vecs[i].uns, vecs[i].exp_rdata, vecs[i].exp_err);

      // Back-pressure: response must hold while resp_ready stays low, and a
      // competing request presented meanwhile must be ignored.
      drive(1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0);
      req_valid = 1'b1;
      step();
      drive(1'b1, 32'h0000_0010, 32'h0BAD_0BAD, 2'b10, 1'b0);
      step();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d.valid", c), 32'(resp_valid), 32'd1);
         chk($sformatf("stall%0d.rdata", c), resp_rdata,      32'h7FAD_BEEF);
         chk($sformatf("stall%0d.error", c), 32'(resp_error), 32'd0);
         chk($sformatf("stall%0d.ready", c), 32'(req_ready),  32'd0);
         step();
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      chk("stall.idle_valid", 32'(resp_valid), 32'd0);
      chk("stall.idle_ready", 32'(req_ready),  32'd1);
      run_req("stall.reread", 1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0, 32'h7FAD_BEEF, 1'b0);

      // Reset while waiting: store stays committed, response is dropped.
      drive(1'b1, 32'h0000_0020, 32'h1234_5678, 2'b10, 1'b0);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rstw.in_wait", 32'(req_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rstw.valid",     32'(resp_valid), 32'd0);
      chk("rstw.req_ready", 32'(req_ready),  32'd1);
      chk("rstw.rdata",     resp_rdata,      32'd0);
      step();
      chk("rstw.valid_late", 32'(resp_valid), 32'd0);
      run_req("rstw.load", 1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

      // A request presented during reset is not accepted.
      drive(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'b10, 1'b0);
      req_valid = 1'b1;
      reset     = 1'b1;
      step();
      reset     = 1'b0;
      req_valid = 1'b0;
      chk("rstacc.ready", 32'(req_ready), 32'd1);
      step();
      chk("rstacc.valid", 32'(resp_valid), 32'd0);
      run_req("rstacc.load", 1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request accept to resp_valid rising; legal range 1..15.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  initiator takes the response.
REQ-014 SHALL have port resp_rdata  output  32  load result, 0 for stores and errors.
REQ-015 SHALL have port resp_error  output  1  request was misaligned, illegal size or out of range.

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, combinationally.
REQ-017 SHALL accept a request on an edge where state is IDLE and req_valid=1, latching write, addr, wdata, size, unsigned.
REQ-018 SHALL move IDLE->RESP directly when LATENCY=1, else IDLE->WAIT, counting LATENCY-1 edges in WAIT, then ->RESP.
REQ-019 SHALL assert resp_valid exactly LATENCY edges after the accepting edge, and hold resp_valid, resp_rdata, resp_error stable until an edge with resp_ready=1.
REQ-020 SHALL return RESP->IDLE on the edge with resp_ready=1; no new request is accepted on that edge (req_ready low in RESP).
REQ-021 SHALL flag error when size=11, when half is not 2-byte aligned, when word is not 4-byte aligned, or when addr[31:2] >= DEPTH.
REQ-022 SHALL, on an error, not modify storage and return resp_rdata=0, resp_error=1.
REQ-023 SHALL commit a valid store on the accepting edge, writing only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2 and addr[1]*2+1; word: all lanes) from the low bits of req_wdata.
REQ-024 SHALL form a load result from storage read at the accepting edge, shifted to bit 0 and sign- or zero-extended per req_unsigned to 32 bits; req_unsigned ignored for word.
REQ-025 SHALL ignore req_* inputs while in WAIT or RESP.
REQ-026 SHALL ignore bits addr[31:2] above log2(DEPTH) only after range check passes; no address wrap-around.

Reset
REQ-027 SHALL, on an edge with reset=1, force state IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_error=0, overriding any other event that edge.
REQ-028 SHALL leave storage contents unchanged by reset; a store committed before reset stays committed; a request in WAIT/RESP is dropped with no response.
REQ-029 SHALL not accept a request on an edge where reset=1.

Verification
REQ-030 SHALL test: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata=0xDEADBEEF, resp_error=0, resp_valid exactly 2 edges after each accept.
REQ-031 SHALL test: after REQ-030, store byte 0x7F @0x13, load byte signed @0x13 -> 0x0000007F; load half signed @0x12 -> 0x00007FAD; load byte unsigned @0x10 -> 0x000000EF; load byte signed @0x10 -> 0xFFFFFFEF.
REQ-032 SHALL test: load word @0x11 and load half @0x13 and size=11 @0x10 -> resp_error=1, resp_rdata=0; word @0x10 unchanged on re-read.
REQ-033 SHALL test: store word @4*DEPTH (0x400) -> resp_error=1; load word @0x3FC -> resp_error=0.
REQ-034 SHALL test: resp_ready held 0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout; resp_ready=1 -> IDLE next edge.
REQ-035 SHALL test: assert reset in WAIT after store 0x12345678 @0x20 -> no resp_valid, req_ready=1 after reset; load @0x20 -> 0x12345678.
